// File: rtl/ppu_ctrl_pkg.sv
// Shared types, constants and helpers for the PC-redirect / pipeline-flush control path.
package ppu_ctrl_pkg;

    // Width of one per-source flush-depth field inside SRC_DEPTH.
    localparam int unsigned DEPTH_W = 3;
    // Widest flush vector depth_mask can build (a 3-bit depth reaches at most 7).
    localparam int unsigned MASK_W  = 8;
    // Bubble counter width; BUBBLE_CYCLES is limited to 1..15.
    localparam int unsigned BUB_W   = 4;

    // Redirect source indices; a lower index means a higher priority.
    localparam int unsigned SRC_BR   = 0;
    localparam int unsigned SRC_JALR = 1;
    localparam int unsigned SRC_JAL  = 2;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } rf_state_e;

    // Flush vector with the lowest `depth` bits set (IF/ID upward).
    function automatic logic [MASK_W-1:0] depth_mask(input logic [DEPTH_W-1:0] depth);
        logic [MASK_W-1:0] m;
        m = {MASK_W{1'b0}};
        for (int i = 0; i < int'(MASK_W); i++) begin
            m[i] = (i < int'(depth));
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 wins. Reports the winner, whether any bit is set,
// and whether more than one bit is set.
module prio_enc #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic             multi_o
);

    // Scan from the lowest-priority bit down so the lowest set index is written last;
    // with no request the index reads N (the "no source" code).
    always_comb begin
        idx_o = IDX_W'(N);
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? IDX_W'(i) : idx_o;
        end
    end

    // Any-request flag, and more-than-one detection by clearing the lowest set bit.
    always_comb begin
        valid_o = |req_i;
        multi_o = |(req_i & (req_i - N'(1'b1)));
    end

endmodule

// File: rtl/redirect_flush_ctrl.sv
// PC-redirect and pipeline-flush controller. Arbitrates the redirect sources, holds the
// PC-source select and flush vector for a bubble window, captures requests while the
// pipeline is stalled, flags multi-source collisions and counts applied redirects.
// Every output comes straight from a register.
module redirect_flush_ctrl
    import ppu_ctrl_pkg::*;
#(
    parameter int unsigned                 NUM_STAGES    = 5,
    parameter int unsigned                 SRC_CNT       = 3,
    parameter logic [DEPTH_W*SRC_CNT-1:0]  SRC_DEPTH     = {3'd1, 3'd1, 3'd2},
    parameter int unsigned                 BUBBLE_CYCLES = 1,
    parameter int unsigned                 CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SRC_CNT-1:0]           redirect_req_i,
    input  logic                         stall_i,
    input  logic                         cnt_clr_i,
    output logic [$clog2(SRC_CNT+1)-1:0] pc_sel_o,
    output logic                         pc_mux_o,
    output logic [NUM_STAGES-2:0]        flush_o,
    output logic                         busy_o,
    output logic                         collision_o,
    output logic [CNT_W-1:0]             redirect_cnt_o
);

    localparam int unsigned SEL_W   = $clog2(SRC_CNT + 1);
    localparam int unsigned FLUSH_W = NUM_STAGES - 1;

    // Arbitration results.
    logic [SEL_W-1:0]   win_s;
    logic               win_valid_s;
    logic               win_multi_s;

    // FSM and bubble state.
    rf_state_e          state_q, state_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [BUB_W-1:0]   bub_q, bub_d;
    logic               inc_s;
    logic               accept_multi_s;

    // Flush depth of the source that will be presented next cycle.
    logic [DEPTH_W-1:0] depth_s;
    logic [MASK_W-1:0]  mask_s;

    // Registered outputs.
    logic [SEL_W-1:0]   pc_sel_q, pc_sel_d;
    logic               pc_mux_q, pc_mux_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               busy_q, busy_d;
    logic               coll_q, coll_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;

    prio_enc #(
        .N     (SRC_CNT),
        .IDX_W (SEL_W)
    ) u_prio_enc (
        .req_i   (redirect_req_i),
        .idx_o   (win_s),
        .valid_o (win_valid_s),
        .multi_o (win_multi_s)
    );

    // Next-state logic: accept in IDLE, upgrade or release in PENDING, count down in FLUSH.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        bub_d          = bub_q;
        inc_s          = 1'b0;
        accept_multi_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    src_d          = win_s;
                    accept_multi_s = win_multi_s;
                    if (stall_i) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_FLUSH;
                        bub_d   = BUB_W'(BUBBLE_CYCLES);
                        inc_s   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // Only a strictly higher-priority source may displace the captured one.
                if (win_valid_s && (win_s < src_q)) begin
                    src_d          = win_s;
                    accept_multi_s = win_multi_s;
                end else begin
                    src_d = src_q;
                end
                if (!stall_i) begin
                    state_d = ST_FLUSH;
                    bub_d   = BUB_W'(BUBBLE_CYCLES);
                    inc_s   = 1'b1;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_FLUSH: begin
                // Requests seen here belong to instructions being flushed and are dropped.
                if (stall_i) begin
                    state_d = ST_FLUSH;
                end else if (bub_q <= BUB_W'(1)) begin
                    state_d = ST_IDLE;
                    bub_d   = {BUB_W{1'b0}};
                end else begin
                    bub_d   = bub_q - BUB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = SEL_W'(SRC_CNT);
                bub_d   = {BUB_W{1'b0}};
            end
        endcase
    end

    // Look up the flush depth of the next-cycle source from the packed depth table.
    always_comb begin
        depth_s = {DEPTH_W{1'b0}};
        for (int s = 0; s < int'(SRC_CNT); s++) begin
            depth_s = (src_d == SEL_W'(s)) ? SRC_DEPTH[DEPTH_W*s +: DEPTH_W] : depth_s;
        end
        mask_s = depth_mask(depth_s);
    end

    // Output next-values follow the next state so a request at edge T shows at T+1.
    always_comb begin
        pc_sel_d = SEL_W'(SRC_CNT);
        pc_mux_d = 1'b0;
        flush_d  = {FLUSH_W{1'b0}};
        busy_d   = (state_d != ST_IDLE);
        coll_d   = accept_multi_s;
        if (state_d == ST_FLUSH) begin
            pc_sel_d = src_d;
            pc_mux_d = 1'b1;
            flush_d  = mask_s[FLUSH_W-1:0];
        end else begin
            pc_sel_d = SEL_W'(SRC_CNT);
            pc_mux_d = 1'b0;
            flush_d  = {FLUSH_W{1'b0}};
        end
    end

    // Saturating redirect counter; a clear coinciding with a redirect leaves a count of one.
    always_comb begin
        rcnt_d = rcnt_q;
        if (cnt_clr_i) begin
            rcnt_d = inc_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (inc_s && (rcnt_q != {CNT_W{1'b1}})) begin
            rcnt_d = rcnt_q + CNT_W'(1);
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // FSM, captured source and bubble counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= SEL_W'(SRC_CNT);
            bub_q   <= {BUB_W{1'b0}};
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            bub_q   <= bub_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_sel_q <= SEL_W'(SRC_CNT);
            pc_mux_q <= 1'b0;
            flush_q  <= {FLUSH_W{1'b0}};
            busy_q   <= 1'b0;
            coll_q   <= 1'b0;
            rcnt_q   <= {CNT_W{1'b0}};
        end else begin
            pc_sel_q <= pc_sel_d;
            pc_mux_q <= pc_mux_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
            coll_q   <= coll_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign pc_sel_o       = pc_sel_q;
    assign pc_mux_o       = pc_mux_q;
    assign flush_o        = flush_q;
    assign busy_o         = busy_q;
    assign collision_o    = coll_q;
    assign redirect_cnt_o = rcnt_q;

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// Directed bench for redirect_flush_ctrl. Three instances: default parameters, a
// three-cycle bubble, and an 8-bit statistics counter so saturation is reachable quickly.
module tb_redirect_flush_ctrl;
    import ppu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0] req_a, req_b, req_c;
    logic       stall_a, stall_b, stall_c;
    logic       clr_a, clr_b, clr_c;

    logic [1:0] sel_a, sel_b, sel_c;
    logic       mux_a, mux_b, mux_c;
    logic [3:0] flush_a, flush_b, flush_c;
    logic       busy_a, busy_b, busy_c;
    logic       coll_a, coll_b, coll_c;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    redirect_flush_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .redirect_req_i(req_a), .stall_i(stall_a), .cnt_clr_i(clr_a),
        .pc_sel_o(sel_a), .pc_mux_o(mux_a), .flush_o(flush_a), .busy_o(busy_a),
        .collision_o(coll_a), .redirect_cnt_o(cnt_a)
    );

    redirect_flush_ctrl #(.BUBBLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .redirect_req_i(req_b), .stall_i(stall_b), .cnt_clr_i(clr_b),
        .pc_sel_o(sel_b), .pc_mux_o(mux_b), .flush_o(flush_b), .busy_o(busy_b),
        .collision_o(coll_b), .redirect_cnt_o(cnt_b)
    );

    redirect_flush_ctrl #(.CNT_W(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .redirect_req_i(req_c), .stall_i(stall_c), .cnt_clr_i(clr_c),
        .pc_sel_o(sel_c), .pc_mux_o(mux_c), .flush_o(flush_c), .busy_o(busy_c),
        .collision_o(coll_c), .redirect_cnt_o(cnt_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stall pattern and request applied in each FLUSH cycle of the 3-cycle-bubble instance.
    logic       b_stall_pat [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] b_req_pat   [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};

    initial begin
        rst_n = 1'b0;
        req_a = 3'b000; stall_a = 1'b0; clr_a = 1'b0;
        req_b = 3'b000; stall_b = 1'b0; clr_b = 1'b0;
        req_c = 3'b000; stall_c = 1'b0; clr_c = 1'b0;

        // Reset state
        #12;
        check_eq("rst_sel",   sel_a, SRC_CNT_EXP());
        check_eq("rst_mux",   mux_a, 1'b0);
        check_eq("rst_flush", flush_a, 4'b0000);
        check_eq("rst_busy",  busy_a, 1'b0);
        check_eq("rst_coll",  coll_a, 1'b0);
        check_eq("rst_cnt",   cnt_a, 16'd0);
        #1 rst_n = 1'b1;
        tick();

        // 1. Single branch redirect
        req_a = 3'b001;
        tick();
        check_eq("t1_sel",   sel_a, SRC_BR);
        check_eq("t1_mux",   mux_a, 1'b1);
        check_eq("t1_flush", flush_a, 4'b0011);
        check_eq("t1_busy",  busy_a, 1'b1);
        check_eq("t1_coll",  coll_a, 1'b0);
        check_eq("t1_cnt",   cnt_a, 16'd1);
        req_a = 3'b000;
        tick();
        check_eq("t1_sel_back",   sel_a, 2'd3);
        check_eq("t1_mux_back",   mux_a, 1'b0);
        check_eq("t1_flush_back", flush_a, 4'b0000);
        check_eq("t1_busy_back",  busy_a, 1'b0);
        check_eq("t1_cnt_hold",   cnt_a, 16'd1);

        // 2. JALR + JAL together: JALR wins, collision pulses once
        req_a = 3'b110;
        tick();
        check_eq("t2_sel",   sel_a, SRC_JALR);
        check_eq("t2_flush", flush_a, 4'b0001);
        check_eq("t2_coll",  coll_a, 1'b1);
        check_eq("t2_cnt",   cnt_a, 16'd2);
        req_a = 3'b000;
        tick();
        check_eq("t2_coll_end", coll_a, 1'b0);
        check_eq("t2_sel_back", sel_a, 2'd3);

        // Back-to-back: held request dropped in FLUSH, accepted again in the IDLE gap
        req_a = 3'b011;
        tick();
        check_eq("bb_sel0",  sel_a, SRC_BR);
        check_eq("bb_coll0", coll_a, 1'b1);
        check_eq("bb_cnt0",  cnt_a, 16'd3);
        tick();
        check_eq("bb_gap_mux",  mux_a, 1'b0);
        check_eq("bb_gap_busy", busy_a, 1'b0);
        check_eq("bb_gap_coll", coll_a, 1'b0);
        tick();
        check_eq("bb_again_mux", mux_a, 1'b1);
        check_eq("bb_again_cnt", cnt_a, 16'd4);
        req_a = 3'b000;
        tick();
        check_eq("bb_idle_mux", mux_a, 1'b0);

        // 3. Stalled capture, upgrade to branch, lower priority ignored, then release
        stall_a = 1'b1;
        req_a = 3'b100;
        tick();
        check_eq("t3_busy0",  busy_a, 1'b1);
        check_eq("t3_mux0",   mux_a, 1'b0);
        check_eq("t3_flush0", flush_a, 4'b0000);
        check_eq("t3_cnt0",   cnt_a, 16'd4);
        req_a = 3'b000;
        tick();
        check_eq("t3_busy1", busy_a, 1'b1);
        req_a = 3'b001;
        tick();
        check_eq("t3_busy2", busy_a, 1'b1);
        check_eq("t3_coll2", coll_a, 1'b0);
        req_a = 3'b110;
        tick();
        check_eq("t3_busy3", busy_a, 1'b1);
        check_eq("t3_low_coll", coll_a, 1'b0);
        check_eq("t3_mux3", mux_a, 1'b0);
        req_a = 3'b000;
        stall_a = 1'b0;
        tick();
        check_eq("t3_sel",   sel_a, SRC_BR);
        check_eq("t3_flush", flush_a, 4'b0011);
        check_eq("t3_mux",   mux_a, 1'b1);
        check_eq("t3_cnt",   cnt_a, 16'd5);
        tick();
        check_eq("t3_idle_busy", busy_a, 1'b0);

        // 4. Three-cycle bubble with a two-cycle stall and a dropped request
        req_b = 3'b010;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_flush_held", flush_b, 4'b0001);
            check_eq("t4_sel_held",   sel_b, SRC_JALR);
            check_eq("t4_mux_held",   mux_b, 1'b1);
            stall_b = b_stall_pat[k];
            req_b   = b_req_pat[k];
            tick();
        end
        check_eq("t4_flush_end", flush_b, 4'b0000);
        check_eq("t4_mux_end",   mux_b, 1'b0);
        check_eq("t4_busy_end",  busy_b, 1'b0);
        check_eq("t4_coll_end",  coll_b, 1'b0);
        check_eq("t4_cnt",       cnt_b, 16'd1);

        // 5. Asynchronous reset in the middle of FLUSH
        req_a = 3'b001;
        tick();
        check_eq("t5_pre_mux", mux_a, 1'b1);
        req_a = 3'b000;
        #3 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_sel",   sel_a, 2'd3);
        check_eq("t5_rst_mux",   mux_a, 1'b0);
        check_eq("t5_rst_flush", flush_a, 4'b0000);
        check_eq("t5_rst_busy",  busy_a, 1'b0);
        check_eq("t5_rst_cnt",   cnt_a, 16'd0);
        #2 rst_n = 1'b1;
        tick();
        check_eq("t5_idle_busy", busy_a, 1'b0);
        check_eq("t5_idle_mux",  mux_a, 1'b0);
        req_a = 3'b010;
        tick();
        check_eq("t5_accept_sel", sel_a, SRC_JALR);
        check_eq("t5_accept_cnt", cnt_a, 16'd1);
        req_a = 3'b000;
        tick();

        // 6. Saturation (8-bit counter instance), then clear with and without a redirect
        for (int r = 0; r < 255; r++) begin
            req_c = 3'b001;
            tick();
            req_c = 3'b000;
            tick();
        end
        check_eq("t6_full", cnt_c, 8'hFF);
        req_c = 3'b100;
        tick();
        check_eq("t6_sat_sel", sel_c, SRC_JAL);
        check_eq("t6_sat",     cnt_c, 8'hFF);
        req_c = 3'b000;
        tick();
        req_c = 3'b001;
        clr_c = 1'b1;
        tick();
        check_eq("t6_clr_inc", cnt_c, 8'd1);
        req_c = 3'b000;
        clr_c = 1'b0;
        tick();
        clr_c = 1'b1;
        tick();
        check_eq("t6_clr_only", cnt_c, 8'd0);
        clr_c = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // "No redirect" select code for the default three-source configuration.
    function automatic logic [31:0] SRC_CNT_EXP();
        return 32'd3;
    endfunction

endmodule
